// File: rtl/fpu_result_arbiter.sv
// Merges execute and load-return FPU results into one registered XIF result port.
// Define RVFPM_RR_ARB_EN for round-robin arbitration; otherwise the load FIFO has fixed priority.

module fpu_result_fifo #(
    parameter int IDW   = 4,
    parameter int PW    = 38,
    parameter int DEPTH = 2
) (
    input  logic           ck,
    input  logic           rst,
    input  logic           push_valid,
    output logic           push_ready,
    input  logic [IDW-1:0] push_id,
    input  logic [PW-1:0]  push_payload,
    input  logic           kill_valid,
    input  logic [IDW-1:0] kill_id,
    input  logic           pop,
    output logic           head_valid,
    output logic           head_live,
    output logic [IDW-1:0] head_id,
    output logic [PW-1:0]  head_payload
);
    localparam int AW = $clog2(DEPTH);

    logic [IDW-1:0]   id_q      [DEPTH];
    logic [PW-1:0]    payload_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW-1:0]    widx;
    logic [AW-1:0]    ridx;
    logic             push;

    assign widx = wptr[AW-1:0];
    assign ridx = rptr[AW-1:0];

    // The extra pointer bit tells full (MSBs differ) from empty (pointers equal).
    assign push_ready   = !((wptr[AW] != rptr[AW]) && (widx == ridx));
    assign head_valid   = (wptr != rptr);
    assign push         = push_valid && push_ready;
    assign head_id      = id_q[ridx];
    assign head_payload = payload_q[ridx];
    assign head_live    = live_q[ridx] && !(kill_valid && (id_q[ridx] == kill_id));

    always_ff @(posedge ck) begin
        if (!rst) begin
            wptr   <= '0;
            rptr   <= '0;
            live_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_valid && (id_q[i] == kill_id)) begin
                    live_q[i] <= 1'b0;
                end
            end
            // A same-cycle kill of the incoming id stores it already dead.
            if (push) begin
                live_q[widx] <= !(kill_valid && (push_id == kill_id));
                wptr         <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    // NOTE: entry storage has no reset; the pointers and live bits decide what is meaningful.
    always_ff @(posedge ck) begin
        if (push) begin
            id_q[widx]      <= push_id;
            payload_q[widx] <= push_payload;
        end
    end
endmodule

module fpu_result_arbiter #(
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [X_ID_WIDTH-1:0] ex_id,
    input  logic [FLEN-1:0]       ex_data,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_we,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [X_ID_WIDTH-1:0] mem_id,
    input  logic [FLEN-1:0]       mem_data,
    input  logic [4:0]            mem_rd,
    input  logic                  mem_we,
    input  logic                  commit_valid,
    input  logic [X_ID_WIDTH-1:0] commit_id,
    input  logic                  commit_kill,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [X_ID_WIDTH-1:0] result_id,
    output logic [FLEN-1:0]       result_data,
    output logic [4:0]            result_rd,
    output logic                  result_we
);
    localparam int PW = FLEN + 6;

    logic                  kill_valid;
    logic                  ex_head_valid, ex_head_live, ex_elig, ex_pop;
    logic                  ld_head_valid, ld_head_live, ld_elig, ld_pop;
    logic [X_ID_WIDTH-1:0] ex_head_id, ld_head_id;
    logic [PW-1:0]         ex_head_payload, ld_head_payload;
    logic                  load_en;
    logic                  grant_ex, grant_ld;

    assign kill_valid = commit_valid && commit_kill;

    fpu_result_fifo #(.IDW(X_ID_WIDTH), .PW(PW), .DEPTH(DEPTH)) u_ex_fifo (
        .ck           (ck),
        .rst          (rst),
        .push_valid   (ex_valid),
        .push_ready   (ex_ready),
        .push_id      (ex_id),
        .push_payload ({ex_data, ex_rd, ex_we}),
        .kill_valid   (kill_valid),
        .kill_id      (commit_id),
        .pop          (ex_pop),
        .head_valid   (ex_head_valid),
        .head_live    (ex_head_live),
        .head_id      (ex_head_id),
        .head_payload (ex_head_payload)
    );

    fpu_result_fifo #(.IDW(X_ID_WIDTH), .PW(PW), .DEPTH(DEPTH)) u_ld_fifo (
        .ck           (ck),
        .rst          (rst),
        .push_valid   (mem_valid),
        .push_ready   (mem_ready),
        .push_id      (mem_id),
        .push_payload ({mem_data, mem_rd, mem_we}),
        .kill_valid   (kill_valid),
        .kill_id      (commit_id),
        .pop          (ld_pop),
        .head_valid   (ld_head_valid),
        .head_live    (ld_head_live),
        .head_id      (ld_head_id),
        .head_payload (ld_head_payload)
    );

    assign ex_elig = ex_head_valid && ex_head_live;
    assign ld_elig = ld_head_valid && ld_head_live;
    assign load_en = !result_valid || result_ready;

`ifdef RVFPM_RR_ARB_EN
    logic last_ld;

    always_ff @(posedge ck) begin
        if (!rst) begin
            last_ld <= 1'b0;
        end else if (grant_ex || grant_ld) begin
            last_ld <= grant_ld;
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_ex = 1'b0;
        grant_ld = 1'b0;
        if (load_en) begin
`ifdef RVFPM_RR_ARB_EN
            if (ex_elig && ld_elig) begin
                grant_ld = !last_ld;
                grant_ex = last_ld;
            end else begin
                grant_ex = ex_elig;
                grant_ld = ld_elig;
            end
`else
            grant_ld = ld_elig;
            grant_ex = ex_elig && !ld_elig;
`endif
        end
    end

    // Dead heads drain without a grant, in parallel with any granted pop.
    assign ex_pop = grant_ex || (ex_head_valid && !ex_head_live);
    assign ld_pop = grant_ld || (ld_head_valid && !ld_head_live);

    always_ff @(posedge ck) begin
        if (!rst) begin
            result_valid <= 1'b0;
            result_id    <= '0;
            result_data  <= '0;
            result_rd    <= '0;
            result_we    <= 1'b0;
        end else if (load_en) begin
            result_valid <= grant_ex || grant_ld;
            if (grant_ld) begin
                result_id                            <= ld_head_id;
                {result_data, result_rd, result_we}  <= ld_head_payload;
            end else if (grant_ex) begin
                result_id                            <= ex_head_id;
                {result_data, result_rd, result_we}  <= ex_head_payload;
            end
        end
    end
endmodule

// File: tb/tb_fpu_result_arbiter.sv
// Scoreboard bench for fpu_result_arbiter: directed stimulus queues expectations,
// a negedge monitor checks every handshaken result and output stability under stall.

module tb_fpu_result_arbiter;
    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_ready;
    logic [3:0]  ex_id = '0;
    logic [31:0] ex_data = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_we = 1'b0;
    logic        mem_valid = 1'b0, mem_ready;
    logic [3:0]  mem_id = '0;
    logic [31:0] mem_data = '0;
    logic [4:0]  mem_rd = '0;
    logic        mem_we = 1'b0;
    logic        commit_valid = 1'b0;
    logic [3:0]  commit_id = '0;
    logic        commit_kill = 1'b0;
    logic        result_valid, result_ready = 1'b1;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_stall = 1'b0;
    exp_t prev_out;

    fpu_result_arbiter #(.X_ID_WIDTH(4), .FLEN(32), .DEPTH(2)) dut (
        .ck           (ck),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_id        (ex_id),
        .ex_data      (ex_data),
        .ex_rd        (ex_rd),
        .ex_we        (ex_we),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_id       (mem_id),
        .mem_data     (mem_data),
        .mem_rd       (mem_rd),
        .mem_we       (mem_we),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_kill  (commit_kill),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_id    (result_id),
        .result_data  (result_data),
        .result_rd    (result_rd),
        .result_we    (result_we)
    );

    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge ck) begin : monitor
        exp_t cur;
        exp_t e;
        cur = {result_id, result_data, result_rd, result_we};
        if (rst) begin
            if (prev_stall) begin
                check("hold_valid", 64'(result_valid), 64'd1);
                check("hold_fields", 64'(cur), 64'(prev_out));
            end
            if (result_valid && result_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got id=%0d data=0x%0h, expected no output", result_id, result_data);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'(cur), 64'(e));
                end
            end
            prev_stall = result_valid && !result_ready;
            prev_out   = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic idle();
        ex_valid     = 1'b0;
        mem_valid    = 1'b0;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic drive_ex(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd, input logic we);
        ex_valid = 1'b1;
        ex_id    = id;
        ex_data  = d;
        ex_rd    = rd;
        ex_we    = we;
    endtask

    task automatic drive_mem(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd, input logic we);
        mem_valid = 1'b1;
        mem_id    = id;
        mem_data  = d;
        mem_rd    = rd;
        mem_we    = we;
    endtask

    task automatic expect_out(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd, input logic we);
        sb.push_back({id, d, rd, we});
    endtask

    task automatic kill(input logic [3:0] id);
        commit_valid = 1'b1;
        commit_kill  = 1'b1;
        commit_id    = id;
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check(name, 64'(sb.size()), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_ex_ready", 64'(ex_ready), 64'd1);
        check("rst_mem_ready", 64'(mem_ready), 64'd1);
        check("rst_result_fields", 64'({result_id, result_data, result_rd, result_we}), 64'd0);

        // Two-cycle latency from push to presented result
        drive_ex(4'd3, 32'h3F80_0000, 5'd5, 1'b1);
        expect_out(4'd3, 32'h3F80_0000, 5'd5, 1'b1);
        tick();
        idle();
        check("lat_n1_valid", 64'(result_valid), 64'd0);
        tick();
        check("lat_n2_valid", 64'(result_valid), 64'd1);
        check("lat_n2_id", 64'(result_id), 64'd3);
        wait_drain("drain_latency");

        // Backpressure: output holds, ex FIFO fills after two more pushes
        result_ready = 1'b0;
        drive_ex(4'd1, 32'h1111_1111, 5'd1, 1'b1);
        expect_out(4'd1, 32'h1111_1111, 5'd1, 1'b1);
        tick();
        idle();
        tick();
        check("stall_valid", 64'(result_valid), 64'd1);
        drive_ex(4'd2, 32'h2222_2222, 5'd2, 1'b0);
        expect_out(4'd2, 32'h2222_2222, 5'd2, 1'b0);
        tick();
        drive_ex(4'd4, 32'h4444_4444, 5'd4, 1'b1);
        expect_out(4'd4, 32'h4444_4444, 5'd4, 1'b1);
        tick();
        idle();
        check("stall_ex_ready_full", 64'(ex_ready), 64'd0);
        check("stall_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        tick();
        check("stall_id", 64'(result_id), 64'd1);
        result_ready = 1'b1;
        wait_drain("drain_stall");
        check("ex_ready_after_drain", 64'(ex_ready), 64'd1);

        // Both requesters push together; order depends on arbitration policy
        drive_ex(4'd8, 32'h8888_0008, 5'd8, 1'b1);
        drive_mem(4'd10, 32'hAAAA_000A, 5'd10, 1'b1);
        tick();
        drive_ex(4'd9, 32'h9999_0009, 5'd9, 1'b1);
        drive_mem(4'd11, 32'hBBBB_000B, 5'd11, 1'b0);
        tick();
        idle();
`ifdef RVFPM_RR_ARB_EN
        expect_out(4'd10, 32'hAAAA_000A, 5'd10, 1'b1);
        expect_out(4'd8, 32'h8888_0008, 5'd8, 1'b1);
        expect_out(4'd11, 32'hBBBB_000B, 5'd11, 1'b0);
        expect_out(4'd9, 32'h9999_0009, 5'd9, 1'b1);
`else
        expect_out(4'd10, 32'hAAAA_000A, 5'd10, 1'b1);
        expect_out(4'd11, 32'hBBBB_000B, 5'd11, 1'b0);
        expect_out(4'd8, 32'h8888_0008, 5'd8, 1'b1);
        expect_out(4'd9, 32'h9999_0009, 5'd9, 1'b1);
`endif
        check("burst_ex_full", 64'(ex_ready), 64'd0);
        wait_drain("drain_burst");

        // Kill of a buffered id: it is dropped, the next entry follows
        drive_ex(4'd7, 32'h7777_7777, 5'd7, 1'b1);
        tick();
        drive_ex(4'd6, 32'h6666_6666, 5'd6, 1'b1);
        kill(4'd7);
        expect_out(4'd6, 32'h6666_6666, 5'd6, 1'b1);
        tick();
        idle();
        check("kill_no_valid", 64'(result_valid), 64'd0);
        tick();
        check("kill_next_valid", 64'(result_valid), 64'd1);
        check("kill_next_id", 64'(result_id), 64'd6);
        wait_drain("drain_kill");

        // Push and kill of the same id in one cycle stores it dead
        drive_mem(4'd5, 32'h5555_5555, 5'd15, 1'b1);
        kill(4'd5);
        tick();
        idle();
        drive_mem(4'd12, 32'hCCCC_CCCC, 5'd12, 1'b1);
        expect_out(4'd12, 32'hCCCC_CCCC, 5'd12, 1'b1);
        tick();
        idle();
        wait_drain("drain_push_kill");

        // Kill of an id already presented: it still completes
        result_ready = 1'b0;
        drive_ex(4'd2, 32'h0202_0202, 5'd3, 1'b1);
        expect_out(4'd2, 32'h0202_0202, 5'd3, 1'b1);
        tick();
        idle();
        tick();
        check("presented_id", 64'(result_id), 64'd2);
        kill(4'd2);
        tick();
        idle();
        check("presented_kill_valid", 64'(result_valid), 64'd1);
        check("presented_kill_id", 64'(result_id), 64'd2);
        result_ready = 1'b1;
        wait_drain("drain_presented_kill");

        // Reset with both FIFOs full and a stalled result: nothing survives
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ex_ready) drive_ex(4'(13 + i), 32'hDEAD_0000 + 32'(i), 5'(i), 1'b1);
            else ex_valid = 1'b0;
            if (mem_ready) drive_mem(4'(i), 32'hBEEF_0000 + 32'(i), 5'(20 + i), 1'b1);
            else mem_valid = 1'b0;
            tick();
        end
        idle();
        check("full_ex_ready", 64'(ex_ready), 64'd0);
        check("full_mem_ready", 64'(mem_ready), 64'd0);
        check("full_result_valid", 64'(result_valid), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_result_valid", 64'(result_valid), 64'd0);
        check("midrst_ex_ready", 64'(ex_ready), 64'd1);
        check("midrst_mem_ready", 64'(mem_ready), 64'd1);
        result_ready = 1'b1;
        repeat (6) tick();
        check("midrst_no_stale", 64'(result_valid), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_result_arbiter.md
FPU_RESULT_ARBITER -- requirements
Module: fpu_result_arbiter

Interface
REQ-001 Parameters:
- X_ID_WIDTH, 4, instruction id width.
- FLEN, 32, result data width.
- DEPTH, 2, per-requester buffer entries (power of two, >=2).

REQ-002 Ports (clock and reset first):
- ck  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- ex_valid  in  1  execute-stage result request.
- ex_ready  out  1  execute buffer can accept.
- ex_id  in  X_ID_WIDTH  execute result id.
- ex_data  in  FLEN  execute result data.
- ex_rd  in  5  execute destination register.
- ex_we  in  1  execute register write enable.
- mem_valid  in  1  load-return result request.
- mem_ready  out  1  load buffer can accept.
- mem_id  in  X_ID_WIDTH  load result id.
- mem_data  in  FLEN  load result data.
- mem_rd  in  5  load destination register.
- mem_we  in  1  load register write enable.
- commit_valid  in  1  commit strobe.
- commit_id  in  X_ID_WIDTH  committed/killed id.
- commit_kill  in  1  kill the id.
- result_valid  out  1  XIF result valid.
- result_ready  in  1  XIF result ready.
- result_id  out  X_ID_WIDTH  result id.
- result_data  out  FLEN  result data.
- result_rd  out  5  result destination register.
- result_we  out  1  result write enable.

Function
REQ-003 Each requester SHALL own a DEPTH-entry circular FIFO of {id, data, rd, we, live}; a push occurs when x_valid && x_ready.
REQ-004 x_ready SHALL equal !full of that FIFO, registered-state only, with no combinational path from result_ready.
REQ-005 A single output register SHALL drive result_*; it SHALL load when empty, or when result_valid && result_ready in the same cycle.
REQ-006 Latency: a push in cycle N with an idle output SHALL give result_valid in cycle N+2; back-to-back pops SHALL sustain one result per cycle.
REQ-007 While result_valid=1 && result_ready=0, all result_* SHALL hold stable and result_valid SHALL NOT deassert.
REQ-008 When both FIFO heads are live and eligible, the grant SHALL follow the arbitration policy of REQ-015; exactly one head SHALL pop per load.
REQ-009 commit_valid && commit_kill SHALL clear live on every FIFO entry whose id equals commit_id, in both FIFOs, in that cycle.
REQ-010 Dead heads SHALL be popped without output, one per FIFO per cycle, and SHALL consume no grant.
REQ-011 A killed id already in the output register SHALL still be presented until handshaken; a valid is never retracted.
REQ-012 A push and a kill of the same id in the same cycle SHALL store the entry as dead.
REQ-013 Simultaneous push and pop on a full FIFO SHALL NOT occur, because ready is low when the FIFO is full; a push and pop on a non-full FIFO SHALL keep the count unchanged.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Configuration
REQ-015 With RVFPM_RR_ARB_EN defined, arbitration SHALL be round-robin: a last-grant bit resets to ex, and on conflict the requester not last granted wins. Without RVFPM_RR_ARB_EN, the mem FIFO SHALL have fixed priority over ex.

Reset
REQ-016 With rst=0 at a rising edge, both FIFOs SHALL empty; result_valid=0; result_id, result_data, result_rd, result_we =0; ex_ready=mem_ready=1; last-grant=ex.
REQ-017 Reset mid-transfer SHALL discard all buffered and presented results, with no completion owed.

Verification
REQ-018 Scenario: ex push id=3, data=0x3F800000, rd=5 in cycle 0 -> result_valid=1 in cycle 2 with id=3, data=0x3F800000, rd=5.
REQ-019 Scenario: hold result_ready=0 for 4 cycles with a pending result -> result_* stable; ex FIFO fills; ex_ready=0 after 2 further pushes.
REQ-020 Scenario: ex and mem push every cycle, result_ready=1 -> RR_EN: order alternates mem/ex starting mem. Without RR_EN: all mem results first.
REQ-021 Scenario: push ex id=7, then commit_kill id=7 before it reaches the output -> id 7 is never output; the next entry appears one cycle later.
REQ-022 Scenario: kill id=2 while id=2 is presented -> id 2 is still output and completes on result_ready.
REQ-023 Scenario: rst=0 for one cycle with both FIFOs full -> next cycle result_valid=0, ex_ready=mem_ready=1, and no stale result emerges.
